// File: rtl/mips_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, the memory handshake and AluOp. Optional: CTRL_INSTR_COUNT_EN.
module mips_main_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  AluOp,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_J    = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [3:0] ALU_ADD   = 4'b1010;
    localparam logic [3:0] ALU_SUB   = 4'b1110;
    localparam logic [3:0] ALU_AND   = 4'b1000;
    localparam logic [3:0] ALU_OR    = 4'b1001;
    localparam logic [3:0] ALU_FUNCT = 4'b0000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_R,
        ST_WB_I,
        ST_WB_MEM,
        ST_BRANCH,
        ST_JUMP,
        ST_HALT
    } state_t;

    state_t     state;
    state_t     nxt;
    logic       is_store;
    logic       in_fetch;
    logic       pc_write_q;
    logic [3:0] imm_alu_op;
    logic       unused_zero;

    // The branch decision happens in the datapath through pc_write_cond.
    assign unused_zero = zero;

    always_comb begin
        imm_alu_op = ALU_ADD;
        case (opcode)
            OP_ANDI: imm_alu_op = ALU_AND;
            OP_ORI:  imm_alu_op = ALU_OR;
            default: imm_alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   nxt = ST_FETCH;
            ST_FETCH:  if (mem_ready) nxt = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_R:                     nxt = ST_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI: nxt = ST_EXEC_I;
                    OP_LW, OP_SW:             nxt = ST_ADDR;
                    OP_BEQ:                   nxt = ST_BRANCH;
                    OP_J:                     nxt = ST_JUMP;
                    default:                  nxt = ST_HALT;
                endcase
            end
            ST_EXEC_R: nxt = ST_WB_R;
            ST_EXEC_I: nxt = ST_WB_I;
            ST_ADDR:   nxt = is_store ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: if (mem_ready) nxt = ST_WB_MEM;
            ST_MEM_WR: if (mem_ready) nxt = ST_FETCH;
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: nxt = ST_FETCH;
            ST_HALT:   nxt = ST_HALT;
            default:   nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they are exact Moore decodes
    // of the state register; the immediate ALU op is captured on the DECODE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            is_store      <= 1'b0;
            illegal       <= 1'b0;
            in_fetch      <= 1'b0;
            pc_write_q    <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            i_or_d        <= 1'b0;
            pc_write_cond <= 1'b0;
            pc_src        <= 2'b00;
            reg_write     <= 1'b0;
            reg_dst       <= 1'b0;
            mem_to_reg    <= 1'b0;
            alu_src_a     <= 1'b0;
            alu_src_b     <= 2'b00;
            AluOp         <= 4'b0000;
            halted        <= 1'b0;
        end else begin
            state <= nxt;
            if (state == ST_DECODE) begin
                is_store <= (opcode == OP_SW);
                if (nxt == ST_HALT && opcode != OP_HALT) begin
                    illegal <= 1'b1;
                end
            end

            in_fetch      <= 1'b0;
            pc_write_q    <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            i_or_d        <= 1'b0;
            pc_write_cond <= 1'b0;
            pc_src        <= 2'b00;
            reg_write     <= 1'b0;
            reg_dst       <= 1'b0;
            mem_to_reg    <= 1'b0;
            alu_src_a     <= 1'b0;
            alu_src_b     <= 2'b00;
            AluOp         <= ALU_ADD;
            halted        <= 1'b0;

            case (nxt)
                ST_FETCH: begin
                    in_fetch  <= 1'b1;
                    mem_req   <= 1'b1;
                    alu_src_b <= 2'b01;
                end
                ST_DECODE: begin
                    alu_src_b <= 2'b11;
                end
                ST_EXEC_R: begin
                    alu_src_a <= 1'b1;
                    AluOp     <= ALU_FUNCT;
                end
                ST_EXEC_I: begin
                    alu_src_a <= 1'b1;
                    alu_src_b <= 2'b11;
                    AluOp     <= imm_alu_op;
                end
                ST_ADDR: begin
                    alu_src_a <= 1'b1;
                    alu_src_b <= 2'b11;
                end
                ST_MEM_RD: begin
                    mem_req <= 1'b1;
                    i_or_d  <= 1'b1;
                end
                ST_MEM_WR: begin
                    mem_req <= 1'b1;
                    mem_we  <= 1'b1;
                    i_or_d  <= 1'b1;
                end
                ST_WB_R: begin
                    reg_write <= 1'b1;
                    reg_dst   <= 1'b1;
                end
                ST_WB_I: begin
                    reg_write <= 1'b1;
                end
                ST_WB_MEM: begin
                    reg_write  <= 1'b1;
                    mem_to_reg <= 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a     <= 1'b1;
                    AluOp         <= ALU_SUB;
                    pc_write_cond <= 1'b1;
                    pc_src        <= 2'b01;
                end
                ST_JUMP: begin
                    pc_write_q <= 1'b1;
                    pc_src     <= 2'b10;
                end
                ST_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    AluOp <= ALU_ADD;
                end
            endcase
        end
    end

    // Instruction fetch completes in the same cycle memory answers.
    assign ir_write = in_fetch & mem_ready;
    assign pc_write = pc_write_q | (in_fetch & mem_ready);

`ifdef CTRL_INSTR_COUNT_EN
    logic [15:0] instr_cnt;

    // Every return to FETCH from a working state retires one instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= 16'd0;
        end else if (nxt == ST_FETCH && state != ST_FETCH && state != ST_IDLE) begin
            instr_cnt <= instr_cnt + 16'd1;
        end
    end

    assign instr_count = instr_cnt;
`else
    assign instr_count = 16'd0;
`endif

    property p_req_states;
        @(posedge clk) disable iff (!rst_n)
            mem_req |-> (state == ST_FETCH || state == ST_MEM_RD || state == ST_MEM_WR);
    endproperty
    a_req_states: assert property (p_req_states);

    property p_halted_state;
        @(posedge clk) disable iff (!rst_n)
            halted == (state == ST_HALT);
    endproperty
    a_halted_state: assert property (p_halted_state);

    property p_write_excl;
        @(posedge clk) disable iff (!rst_n)
            !(mem_we && reg_write);
    endproperty
    a_write_excl: assert property (p_write_excl);

endmodule
